// File: rtl/reg_file_sb_if.sv
// Banked register-file port bundle: read ports, write port, issue port and scoreboard status.
// master drives requests (pipeline side); slave is the register file.
interface reg_file_sb_if #(
  parameter int WIDTH = 32,
  parameter int NUM   = 32,
  parameter int BANKS = 2,
  parameter int NRD   = 3
);
  localparam int AW = $clog2(NUM);
  localparam int BW = $clog2(BANKS);

  logic [NRD*BW-1:0]    rd_bank;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [BW-1:0]        wr_bank;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 iss_en;
  logic [BW-1:0]        iss_bank;
  logic [AW-1:0]        iss_addr;
  logic                 any_busy;
  logic                 err_waw;

  modport master (
    output rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data, iss_en, iss_bank, iss_addr,
    input  rd_data, rd_busy, any_busy, err_waw
  );

  modport slave (
    input  rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data, iss_en, iss_bank, iss_addr,
    output rd_data, rd_busy, any_busy, err_waw
  );
endinterface

// File: rtl/reg_file_sb.sv
// Banked register file with per-register busy scoreboard and sticky WAW flag.
// Reads are combinational with write bypass; writes/issues commit on the rising edge; no backpressure.
module reg_file_sb #(
  parameter int WIDTH   = 32,
  parameter int NUM     = 32,
  parameter int BANKS   = 2,
  parameter int NRD     = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic         clk,
  input  logic         rstn,
  reg_file_sb_if.slave bus
);
  localparam int AW    = $clog2(NUM);
  localparam int BW    = $clog2(BANKS);
  localparam int IW    = BW + AW;
  localparam int DEPTH = BANKS * NUM;
  localparam logic [BW:0] BANKS_L = (BW+1)'(BANKS);

  function automatic logic in_range(input logic [BW-1:0] b);
    return {1'b0, b} < BANKS_L;
  endfunction

  function automatic logic is_zero(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (b == '0) && (a == '0);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_waw_q, err_waw_d;
  logic             wr_ok, iss_ok, same_tgt;
  logic [IW-1:0]    widx, iidx;

  assign widx     = {bus.wr_bank, bus.wr_addr};
  assign iidx     = {bus.iss_bank, bus.iss_addr};
  assign wr_ok    = bus.wr_en && in_range(bus.wr_bank) && !is_zero(bus.wr_bank, bus.wr_addr);
  assign iss_ok   = bus.iss_en && in_range(bus.iss_bank) && !is_zero(bus.iss_bank, bus.iss_addr);
  assign same_tgt = wr_ok && (widx == iidx);

  // Issue is applied after the write clear so a simultaneous new producer keeps the register busy.
  always_comb begin
    busy_d    = busy_q;
    err_waw_d = err_waw_q;
    if (wr_ok) begin
      busy_d[widx] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iidx] = 1'b1;
      if (busy_q[iidx] && !same_tgt) begin
        err_waw_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      err_waw_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[widx] <= bus.wr_data;
      end
      busy_q    <= busy_d;
      err_waw_q <= err_waw_d;
    end
  end

  logic [NRD*WIDTH-1:0] rd_data_c;
  logic [NRD-1:0]       rd_busy_c;

  // Bypass is gated by rstn so reset forces every read port to zero.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NRD; k++) begin : g_rd
      logic [BW-1:0] rb;
      logic [AW-1:0] ra;
      logic          byp;
      rb  = bus.rd_bank[k*BW +: BW];
      ra  = bus.rd_addr[k*AW +: AW];
      byp = rstn && bus.wr_en && in_range(bus.wr_bank) &&
            (bus.wr_bank == rb) && (bus.wr_addr == ra);
      if (in_range(rb) && !is_zero(rb, ra)) begin
        if (byp) begin
          rd_data_c[k*WIDTH +: WIDTH] = bus.wr_data;
        end else begin
          rd_data_c[k*WIDTH +: WIDTH] = mem_q[{rb, ra}];
          rd_busy_c[k]                = busy_q[{rb, ra}];
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.any_busy = |busy_q;
  assign bus.err_waw  = err_waw_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Table-driven bench for reg_file_sb: one vector per cycle, expectations routed through a scoreboard queue.
module tb_reg_file_sb;
  localparam int WIDTH = 32;
  localparam int NUM   = 32;
  localparam int BANKS = 2;
  localparam int NRD   = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.WIDTH(WIDTH), .NUM(NUM), .BANKS(BANKS), .NRD(NRD)) bus ();

  reg_file_sb #(.WIDTH(WIDTH), .NUM(NUM), .BANKS(BANKS), .NRD(NRD), .ZERO_R0(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic        wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic        ib;
    logic [4:0]  ia;
    logic        rb [3];
    logic [4:0]  ra [3];
    logic [31:0] ed [3];
    logic        eb [3];
    logic        eany;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] ed [3];
    logic        eb [3];
    logic        eany;
    logic        eerr;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic wb, input int wa, input logic [31:0] wd,
                     input logic ie, input logic ib, input int ia,
                     input logic b0, input int a0, input logic [31:0] d0, input logic y0,
                     input logic b1, input int a1, input logic [31:0] d1, input logic y1,
                     input logic b2, input int a2, input logic [31:0] d2, input logic y2,
                     input logic an, input logic er);
    vec_t v;
    v.we = we; v.wb = wb; v.wa = wa[4:0]; v.wd = wd;
    v.ie = ie; v.ib = ib; v.ia = ia[4:0];
    v.rb[0] = b0; v.ra[0] = a0[4:0]; v.ed[0] = d0; v.eb[0] = y0;
    v.rb[1] = b1; v.ra[1] = a1[4:0]; v.ed[1] = d1; v.eb[1] = y1;
    v.rb[2] = b2; v.ra[2] = a2[4:0]; v.ed[2] = d2; v.eb[2] = y2;
    v.eany = an; v.eerr = er;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_bank = '0; bus.iss_addr = '0;
    bus.rd_bank = '0; bus.rd_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    bus.wr_en = v.we; bus.wr_bank = v.wb; bus.wr_addr = v.wa; bus.wr_data = v.wd;
    bus.iss_en = v.ie; bus.iss_bank = v.ib; bus.iss_addr = v.ia;
    bus.rd_bank = {v.rb[2], v.rb[1], v.rb[0]};
    bus.rd_addr = {v.ra[2], v.ra[1], v.ra[0]};
    e.ed = v.ed; e.eb = v.eb; e.eany = v.eany; e.eerr = v.eerr;
    sb.push_back(e);
  endtask

  task automatic sample(input int id);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL v%0d scoreboard: got empty queue, expected an entry", id);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("v%0d rd_data%0d", id, k), bus.rd_data[k*WIDTH +: WIDTH], e.ed[k]);
        check($sformatf("v%0d rd_busy%0d", id, k), 32'(bus.rd_busy[k]), 32'(e.eb[k]));
      end
      check($sformatf("v%0d any_busy", id), 32'(bus.any_busy), 32'(e.eany));
      check($sformatf("v%0d err_waw", id), 32'(bus.err_waw), 32'(e.eerr));
    end
  endtask

  task automatic run_table();
    while (vt.size() != 0) begin
      vec_t v;
      v = vt.pop_front();
      @(posedge clk);
      #1;
      drive(v);
      n_vec++;
      @(negedge clk);
      sample(n_vec);
    end
  endtask

  initial begin
    idle_inputs();
    // Write and issue to b1 r3 while reset is held: no bypass, no state change.
    bus.wr_en = 1'b1; bus.wr_bank = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEADBEEF;
    bus.iss_en = 1'b1; bus.iss_bank = 1'b1; bus.iss_addr = 5'd3;
    bus.rd_bank = 3'b001; bus.rd_addr = {5'd0, 5'd0, 5'd3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd_data0", bus.rd_data[31:0], 32'h0);
    check("reset rd_busy0", 32'(bus.rd_busy[0]), 32'h0);
    check("reset any_busy", 32'(bus.any_busy), 32'h0);
    check("reset err_waw", 32'(bus.err_waw), 32'h0);
    idle_inputs();
    rstn = 1'b1;

    //   we wb wa wd            ie ib ia  port0              port1              port2              any err
    add(1,0, 5,32'h12345678, 0,0, 0,  0, 5,32'h12345678,0, 1, 3,32'h0,0,       0, 0,32'h0,0,       0,0);
    add(0,0, 0,32'h0,        0,0, 0,  0, 5,32'h12345678,0, 1, 5,32'h0,0,       0, 4,32'h0,0,       0,0);
    add(1,1, 3,32'hDEADBEEF, 0,0, 0,  1, 3,32'hDEADBEEF,0, 0, 3,32'h0,0,       0, 5,32'h12345678,0,0,0);
    add(1,0, 0,32'hFFFFFFFF, 1,0, 0,  0, 0,32'h0,0,        1, 3,32'hDEADBEEF,0,1, 0,32'h0,0,       0,0);
    add(1,1, 0,32'hFFFFFFFF, 0,0, 0,  0, 0,32'h0,0,        1, 0,32'hFFFFFFFF,0,0, 3,32'h0,0,       0,0);
    add(0,0, 0,32'h0,        1,0, 7,  1, 0,32'hFFFFFFFF,0, 0, 7,32'h0,0,       0, 5,32'h12345678,0,0,0);
    add(0,0, 0,32'h0,        0,0, 0,  0, 7,32'h0,1,        1, 7,32'h0,0,       0, 0,32'h0,0,       1,0);
    add(1,0, 7,32'h1,        0,0, 0,  0, 7,32'h1,0,        0, 7,32'h1,0,       1, 7,32'h0,0,       1,0);
    add(0,0, 0,32'h0,        0,0, 0,  0, 7,32'h1,0,        1, 0,32'hFFFFFFFF,0,1, 3,32'hDEADBEEF,0,0,0);
    add(0,0, 0,32'h0,        1,0,10,  0,10,32'h0,0,        0, 7,32'h1,0,       0, 0,32'h0,0,       0,0);
    add(1,0,10,32'hA,        1,0,10,  0,10,32'hA,0,        1,10,32'h0,0,       0, 7,32'h1,0,       1,0);
    add(0,0, 0,32'h0,        0,0, 0,  0,10,32'hA,1,        0, 0,32'h0,0,       0, 0,32'h0,0,       1,0);
    add(1,0,10,32'hB,        0,0, 0,  0,10,32'hB,0,        0, 0,32'h0,0,       0, 0,32'h0,0,       1,0);
    add(1,1, 9,32'h77,       1,0, 9,  0, 9,32'h0,0,        1, 9,32'h77,0,      0,10,32'hB,0,       0,0);
    add(0,0, 0,32'h0,        1,0, 9,  0, 9,32'h0,1,        1, 9,32'h77,0,      0, 0,32'h0,0,       1,0);
    add(0,0, 0,32'h0,        0,0, 0,  0, 9,32'h0,1,        0, 0,32'h0,0,       0, 0,32'h0,0,       1,1);
    add(1,0, 9,32'h99,       0,0, 0,  0, 9,32'h99,0,       0, 0,32'h0,0,       0, 0,32'h0,0,       1,1);
    add(0,0, 0,32'h0,        0,0, 0,  0, 9,32'h99,0,       0,10,32'hB,0,       0, 0,32'h0,0,       0,1);
    add(1,0, 4,32'h55,       0,0, 0,  0, 4,32'h55,0,       0, 0,32'h0,0,       0, 0,32'h0,0,       0,1);
    add(0,0, 0,32'h0,        1,0, 4,  0, 4,32'h55,0,       0, 0,32'h0,0,       0, 0,32'h0,0,       0,1);
    run_table();

    // r4 pending with 0x55, then a half-cycle reset pulse clears everything asynchronously.
    @(posedge clk);
    #1;
    idle_inputs();
    bus.rd_addr = {5'd0, 5'd0, 5'd4};
    @(negedge clk);
    check("pre-reset rd_data0", bus.rd_data[31:0], 32'h55);
    check("pre-reset rd_busy0", 32'(bus.rd_busy[0]), 32'h1);
    check("pre-reset any_busy", 32'(bus.any_busy), 32'h1);
    check("pre-reset err_waw", 32'(bus.err_waw), 32'h1);
    #1;
    rstn = 1'b0;
    #1;
    check("mid-reset rd_data0", bus.rd_data[31:0], 32'h0);
    check("mid-reset rd_busy0", 32'(bus.rd_busy[0]), 32'h0);
    check("mid-reset any_busy", 32'(bus.any_busy), 32'h0);
    check("mid-reset err_waw", 32'(bus.err_waw), 32'h0);
    #1;
    rstn = 1'b1;

    add(1,1, 2,32'h3C,       0,0, 0,  0, 4,32'h0,0,        0, 5,32'h0,0,       1, 3,32'h0,0,       0,0);
    add(0,0, 0,32'h0,        0,0, 0,  1, 2,32'h3C,0,       0, 4,32'h0,0,       0, 9,32'h0,0,       0,0);
    run_table();

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
